// File: rtl/writeback_unit.sv
// Write-back arbiter: merges single-cycle ALU results and buffered load results onto the one
// register-bank write port, with a starvation guard so buffered loads always drain.
module writeback_unit #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       alu_valid_i,
   input  logic [ADDR_WIDTH-1:0]      alu_rd_i,
   input  logic [DATA_WIDTH-1:0]      alu_data_i,
   input  logic                       mem_valid_i,
   output logic                       mem_ready_o,
   input  logic [ADDR_WIDTH-1:0]      mem_rd_i,
   input  logic [DATA_WIDTH-1:0]      mem_data_i,
   output logic                       we_o,
   output logic [ADDR_WIDTH-1:0]      waddr_o,
   output logic [DATA_WIDTH-1:0]      wdata_o,
   output logic [(2**ADDR_WIDTH)-1:0] pend_o,
   output logic                       alu_stall_o,
   output logic                       err_o
);
   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW    = PtrW + 1;
   localparam int unsigned StW     = $clog2(STARVE_LIMIT + 1);

   logic [ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q, count_d;
   logic [StW-1:0]        starve_q, starve_d;
   logic                  stall_q, err_q, err_d, we_q, from_fifo_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  fifo_empty, alu_wr, sel_fifo, sel_alu, push;
   logic [NumRegs-1:0]    pend;

   assign fifo_empty  = (count_q == '0);
   assign mem_ready_o = (count_q != CntW'(FIFO_DEPTH));
   assign alu_wr      = alu_valid_i && (alu_rd_i != '0);
   // A stalled ALU loses the port to the FIFO head; otherwise the FIFO only fills idle slots.
   assign sel_fifo    = !fifo_empty && (stall_q || !alu_wr);
   assign sel_alu     = alu_wr && !sel_fifo;
   assign push        = mem_valid_i && mem_ready_o && (mem_rd_i != '0);

   always_comb begin
      pend = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (CntW'(i) < count_q) begin
            pend[fifo_rd_q[rd_ptr_q + PtrW'(i)]] = 1'b1;
         end
      end
      if (we_q && from_fifo_q) begin
         pend[waddr_q] = 1'b1;
      end
      pend[0] = 1'b0;
   end

   always_comb begin
      count_d = count_q;
      if (push && !sel_fifo) begin
         count_d = count_q + 1'b1;
      end else if (!push && sel_fifo) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (sel_fifo || fifo_empty) begin
         starve_d = '0;
      end else if (starve_q != StW'(STARVE_LIMIT)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   assign err_d = err_q || (alu_wr && (pend[alu_rd_i] || (stall_q && !fifo_empty)));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_rd_q[i]   <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
         stall_q     <= 1'b0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         from_fifo_q <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd_i;
            fifo_data_q[wr_ptr_q] <= mem_data_i;
            wr_ptr_q              <= wr_ptr_q + 1'b1;
         end
         if (sel_fifo) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q  <= count_d;
         starve_q <= starve_d;
         stall_q  <= (starve_d == StW'(STARVE_LIMIT));
         err_q    <= err_d;
         if (sel_fifo) begin
            we_q        <= 1'b1;
            waddr_q     <= fifo_rd_q[rd_ptr_q];
            wdata_q     <= fifo_data_q[rd_ptr_q];
            from_fifo_q <= 1'b1;
         end else if (sel_alu) begin
            we_q        <= 1'b1;
            waddr_q     <= alu_rd_i;
            wdata_q     <= alu_data_i;
            from_fifo_q <= 1'b0;
         end else begin
            we_q        <= 1'b0;
            from_fifo_q <= 1'b0;
         end
      end
   end

   assign we_o        = we_q;
   assign waddr_o     = waddr_q;
   assign wdata_o     = wdata_q;
   assign pend_o      = pend;
   assign alu_stall_o = stall_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_writeback_unit;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid, mem_valid, mem_ready;
   logic [AW-1:0] alu_rd, mem_rd, waddr;
   logic [DW-1:0] alu_data, mem_data, wdata;
   logic          we, stall, err;
   logic [31:0]   pend;

   int checks = 0;
   int passes = 0;

   writeback_unit #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk_i(clk), .rst_i(rst_n),
      .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
      .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
      .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .pend_o(pend),
      .alu_stall_o(stall), .err_o(err)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [AW-1:0] q_rd[$];
   logic [DW-1:0] q_dat[$];
   logic          m_we, m_from, m_stall, m_err;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   int            m_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
   endtask

   task automatic model_reset();
      q_rd.delete();
      q_dat.delete();
      m_we = 0; m_from = 0; m_stall = 0; m_err = 0;
      m_waddr = '0; m_wdata = '0; m_cnt = 0;
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p = '0;
      foreach (q_rd[i]) p[q_rd[i]] = 1'b1;
      if (m_we && m_from) p[m_waddr] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic model_step();
      bit          alu_wr = alu_valid && (alu_rd != 0);
      bit          nonempty = (q_rd.size() != 0);
      bit          full = (q_rd.size() == DEPTH);
      bit          pop = nonempty && (m_stall || !alu_wr);
      logic [31:0] p = model_pend();
      if (alu_wr && (p[alu_rd] || (m_stall && nonempty))) m_err = 1;
      if (pop) begin
         m_we = 1; m_from = 1;
         m_waddr = q_rd.pop_front();
         m_wdata = q_dat.pop_front();
      end else if (alu_wr) begin
         m_we = 1; m_from = 0; m_waddr = alu_rd; m_wdata = alu_data;
      end else begin
         m_we = 0; m_from = 0;
      end
      if (pop || !nonempty) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
      m_stall = (m_cnt == LIMIT);
      if (mem_valid && !full && mem_rd != 0) begin
         q_rd.push_back(mem_rd);
         q_dat.push_back(mem_data);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_we", we, m_we);
      if (m_we) begin
         chk("cmp_waddr", waddr, m_waddr);
         chk("cmp_wdata", wdata, m_wdata);
      end
      chk("cmp_pend", pend, model_pend());
      chk("cmp_stall", stall, m_stall);
      chk("cmp_err", err, m_err);
      chk("cmp_ready", mem_ready, q_rd.size() != DEPTH);
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; mem_valid = 0;
   endtask

   logic [AW-1:0] got[$];
   int  idx;
   bit  acc;

   initial begin
      model_reset();
      rst_n = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      #12;
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_pend", pend, 0);
      chk("rst_stall", stall, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", mem_ready, 1);
      @(posedge clk); #1; rst_n = 1;
      tick();

      // ALU alone
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick(); idle();
      chk("alu_we", we, 1);
      chk("alu_waddr", waddr, 5);
      chk("alu_wdata", wdata, 32'hDEADBEEF);
      tick();
      chk("alu_we_off", we, 0);
      alu_valid = 1; alu_rd = 0; alu_data = 32'h1111;
      tick(); idle();
      chk("alu_rd0_we", we, 0);
      chk("alu_rd0_err", err, 0);
      tick();

      // Load alone
      mem_valid = 1; mem_rd = 7; mem_data = 32'h12345678;
      tick(); idle();
      chk("ld_pend_c2", pend, 32'h80);
      chk("ld_we_c2", we, 0);
      tick();
      chk("ld_we_c3", we, 1);
      chk("ld_waddr_c3", waddr, 7);
      chk("ld_wdata_c3", wdata, 32'h12345678);
      chk("ld_pend_c3", pend, 32'h80);
      tick();
      chk("ld_pend_c4", pend, 0);
      tick();

      // Backpressure with continuous ALU traffic to r9
      idx = 0; got.delete();
      for (int c = 0; c < 40 && got.size() < 3; c++) begin
         mem_valid = (idx < 3); mem_rd = AW'(idx + 1); mem_data = 32'hA0 + idx;
         alu_valid = !stall; alu_rd = 9; alu_data = 32'h9000_0000 + c;
         acc = mem_valid && mem_ready;
         tick();
         if (acc) begin
            idx++;
            if (idx == 2) chk("bp_ready_low", mem_ready, 0);
         end
         if (we && waddr != 9) got.push_back(waddr);
      end
      idle();
      chk("bp_count", got.size(), 3);
      for (int i = 0; i < got.size() && i < 3; i++) chk("bp_order", got[i], i + 1);
      chk("bp_err", err, 0);
      tick(); tick();

      // Starvation: one load, ALU honours the stall
      alu_valid = 1; alu_rd = 9; alu_data = 32'h77;
      mem_valid = 1; mem_rd = 12; mem_data = 32'h00C0FFEE;
      tick(); mem_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         chk("st_no_stall", stall, 0);
         tick();
      end
      chk("st_stall", stall, 1);
      alu_valid = 0;
      tick();
      chk("st_we", we, 1);
      chk("st_waddr", waddr, 12);
      chk("st_wdata", wdata, 32'h00C0FFEE);
      chk("st_stall_off", stall, 0);
      chk("st_err", err, 0);
      tick();

      // WAW error
      mem_valid = 1; mem_rd = 20; mem_data = 32'h55;
      tick(); mem_valid = 0;
      alu_valid = 1; alu_rd = 20; alu_data = 32'h2020;
      tick(); idle();
      chk("waw_err", err, 1);
      chk("waw_alu_waddr", waddr, 20);
      tick();
      chk("waw_ld_wdata", wdata, 32'h55);
      tick(); tick();
      chk("waw_err_sticky", err, 1);

      // Async reset with two buffered loads and a live write
      alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
      mem_valid = 1; mem_rd = 3; mem_data = 32'h33;
      tick();
      mem_rd = 4; mem_data = 32'h44;
      tick(); idle();
      chk("ar_pre_we", we, 1);
      chk("ar_pre_pend", pend, 32'h18);
      #2; rst_n = 0; model_reset();
      #1;
      chk("ar_we", we, 0);
      chk("ar_waddr", waddr, 0);
      chk("ar_wdata", wdata, 0);
      chk("ar_pend", pend, 0);
      chk("ar_stall", stall, 0);
      chk("ar_err", err, 0);
      chk("ar_ready", mem_ready, 1);
      tick(); tick();
      rst_n = 1;
      for (int k = 0; k < 4; k++) tick();
      chk("ar_no_stale_we", we, 0);
      chk("ar_no_stale_pend", pend, 0);

      // ALU valid during stall: ALU write dropped, error flagged
      alu_valid = 1; alu_rd = 9; alu_data = 32'h1;
      mem_valid = 1; mem_rd = 15; mem_data = 32'h77;
      tick(); mem_valid = 0;
      for (int k = 1; k <= 4; k++) tick();
      chk("sv_stall", stall, 1);
      alu_rd = 10; alu_data = 32'hBAD;
      tick(); idle();
      chk("sv_we", we, 1);
      chk("sv_waddr", waddr, 15);
      chk("sv_wdata", wdata, 32'h77);
      chk("sv_err", err, 1);
      tick();
      chk("sv_no_alu_we", we, 0);
      chk("sv_err_sticky", err, 1);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
